smm_tile_streamer: RTL



---
 rtl/smm_tile_streamer.sv | 124 ++++++++++++
 1 files changed

// File: rtl/smm_tile_streamer.sv
// Element-stream front/back end for the 2x2 Strassen multiply core: packs an A and
// a B tile, pulses load, waits a fixed latency, then streams the four C elements out.
module smm_tile_streamer #(
  parameter int DATAWIDTH      = 32,
  parameter int BUSWIDTH       = DATAWIDTH * 4,
  parameter int RESULT_LATENCY = 9
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATAWIDTH-1:0] in_data,
  input  logic                 in_sel,
  output logic [BUSWIDTH-1:0]  A_out,
  output logic [BUSWIDTH-1:0]  B_out,
  output logic                 load,
  output logic                 sel,
  input  logic [BUSWIDTH-1:0]  C_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATAWIDTH-1:0] out_data,
  output logic                 out_last,
  output logic                 busy
);

  localparam int WAIT_W = (RESULT_LATENCY > 1) ? $clog2(RESULT_LATENCY + 1) : 1;

  typedef enum logic [1:0] {
    S_FILL,
    S_ISSUE,
    S_WAIT,
    S_DRAIN
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [2:0]          elem_cnt;
  logic [1:0]          out_idx;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [BUSWIDTH-1:0] a_q;
  logic [BUSWIDTH-1:0] b_q;
  logic [BUSWIDTH-1:0] cap_q;
  logic                sel_q;
  logic                in_fire;
  logic                out_fire;
  logic                wait_done;

  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign wait_done = (state == S_WAIT) && (wait_cnt == WAIT_W'(RESULT_LATENCY - 1));

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values, independent of process ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_FILL;
    else        state <= state_nxt;
  end

  // NOTE: the default assignment at the top keeps this block free of inferred latches.
  always_comb begin
    state_nxt = state;
    case (state)
      S_FILL:  if (in_fire && elem_cnt == 3'd7) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (wait_done) state_nxt = S_DRAIN;
      S_DRAIN: if (out_fire && out_idx == 2'd3) state_nxt = S_FILL;
      default: state_nxt = S_FILL;
    endcase
  end

  // in_ready is gated by rst_n so it reads 0 for the whole reset cycle.
  always_comb begin
    in_ready  = 1'b0;
    load      = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    busy      = 1'b1;
    case (state)
      S_FILL: begin
        in_ready = rst_n;
        busy     = (elem_cnt != 3'd0);
      end
      S_ISSUE: load = 1'b1;
      S_DRAIN: begin
        out_valid = 1'b1;
        out_data  = cap_q[int'(out_idx) * DATAWIDTH +: DATAWIDTH];
        out_last  = (out_idx == 2'd3);
      end
      default: ;
    endcase
  end

  // NOTE: the tile and capture registers are reset because their contents are
  // visible on the ports and must read 0 after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      elem_cnt <= '0;
      out_idx  <= '0;
      wait_cnt <= '0;
      a_q      <= '0;
      b_q      <= '0;
      cap_q    <= '0;
      sel_q    <= 1'b0;
    end else begin
      if (in_fire) begin
        if (!elem_cnt[2]) a_q[int'(elem_cnt[1:0]) * DATAWIDTH +: DATAWIDTH] <= in_data;
        else              b_q[int'(elem_cnt[1:0]) * DATAWIDTH +: DATAWIDTH] <= in_data;
        if (elem_cnt == 3'd0) sel_q <= in_sel;
        elem_cnt <= elem_cnt + 3'd1;
      end
      if (state == S_ISSUE)     wait_cnt <= '0;
      else if (state == S_WAIT) wait_cnt <= wait_cnt + WAIT_W'(1);
      if (wait_done) cap_q <= C_in;
      // Both counters wrap to 0 on the last element of a tile.
      if (out_fire) out_idx <= out_idx + 2'd1;
    end
  end

  assign A_out = a_q;
  assign B_out = b_q;
  assign sel   = sel_q;

endmodule
